// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one load/store at a time to the memory
// controller, stalls the pipeline while it is outstanding, and extends load data.
module mem_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [5:0]  cmdtype_in,
  input  logic [4:0]  rsd_addr_in,
  input  logic [31:0] rsd_data_in,
  input  logic        write_rsd_or_not_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] store_data_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [1:0]  mem_len_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_rdata_in,
  output logic        stall_req_out,
  output logic [4:0]  rsd_addr_out,
  output logic [31:0] rsd_data_out,
  output logic        write_rsd_or_not_out
);

  localparam int unsigned CMD_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 2;

  // Instruction-type codes shared with the decoder.
  localparam logic [CMD_W-1:0] CMD_LB  = 6'd11;
  localparam logic [CMD_W-1:0] CMD_LH  = 6'd12;
  localparam logic [CMD_W-1:0] CMD_LW  = 6'd13;
  localparam logic [CMD_W-1:0] CMD_LBU = 6'd14;
  localparam logic [CMD_W-1:0] CMD_LHU = 6'd15;
  localparam logic [CMD_W-1:0] CMD_SB  = 6'd16;
  localparam logic [CMD_W-1:0] CMD_SH  = 6'd17;
  localparam logic [CMD_W-1:0] CMD_SW  = 6'd18;

  localparam logic [LEN_W-1:0] LEN_BYTE = 2'b00;
  localparam logic [LEN_W-1:0] LEN_HALF = 2'b01;
  localparam logic [LEN_W-1:0] LEN_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CMD_W-1:0]    cmd_q;
  logic [DATA_W-1:0]   load_data;
  logic                is_load;
  logic                is_store;
  logic                is_mem;

  function automatic logic [LEN_W-1:0] len_of(input logic [CMD_W-1:0] cmd);
    case (cmd)
      CMD_LB, CMD_LBU, CMD_SB: len_of = LEN_BYTE;
      CMD_LH, CMD_LHU, CMD_SH: len_of = LEN_HALF;
      default:                 len_of = LEN_WORD;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [CMD_W-1:0]  cmd,
                                               input logic [DATA_W-1:0] r);
    case (cmd)
      CMD_LB:  extend = {{24{r[7]}}, r[7:0]};
      CMD_LBU: extend = {24'h0, r[7:0]};
      CMD_LH:  extend = {{16{r[15]}}, r[15:0]};
      CMD_LHU: extend = {16'h0, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  // Command classification of the incoming EX/MEM instruction.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (cmdtype_in)
      CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU: is_load  = 1'b1;
      CMD_SB, CMD_SH, CMD_SW:                   is_store = 1'b1;
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

  // Request FSM; rdy_in low freezes everything, reset wins over all.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_len_out   <= LEN_BYTE;
      cmd_q         <= '0;
      load_data     <= '0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            state         <= ST_BUSY;
            mem_req_out   <= 1'b1;
            mem_we_out    <= is_store;
            mem_addr_out  <= mem_addr_in;
            mem_wdata_out <= store_data_in;
            mem_len_out   <= len_of(cmdtype_in);
            cmd_q         <= cmdtype_in;
          end
        end
        ST_BUSY: begin
          if (mem_done_in) begin
            state       <= ST_DONE;
            mem_req_out <= 1'b0;
            load_data   <= extend(cmd_q, mem_rdata_in);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write-back path and stall request follow the state combinationally.
  always_comb begin
    rsd_addr_out         = rsd_addr_in;
    rsd_data_out         = rsd_data_in;
    write_rsd_or_not_out = 1'b0;
    stall_req_out        = 1'b0;
    if (!rst_in) begin
      case (state)
        ST_IDLE: begin
          if (is_mem) stall_req_out = 1'b1;
          else        write_rsd_or_not_out = write_rsd_or_not_in;
        end
        ST_BUSY: stall_req_out = 1'b1;
        ST_DONE: begin
          rsd_data_out         = load_data;
          write_rsd_or_not_out = !mem_we_out && (rsd_addr_in != 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam logic [5:0] CMD_ADD = 6'd1;
  localparam logic [5:0] CMD_NOP = 6'd0;
  localparam logic [5:0] CMD_LB  = 6'd11;
  localparam logic [5:0] CMD_LH  = 6'd12;
  localparam logic [5:0] CMD_LW  = 6'd13;
  localparam logic [5:0] CMD_LBU = 6'd14;
  localparam logic [5:0] CMD_LHU = 6'd15;
  localparam logic [5:0] CMD_SB  = 6'd16;
  localparam logic [5:0] CMD_SH  = 6'd17;
  localparam logic [5:0] CMD_SW  = 6'd18;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  cmdtype_in;
  logic [4:0]  rsd_addr_in;
  logic [31:0] rsd_data_in;
  logic        write_rsd_or_not_in;
  logic [31:0] mem_addr_in;
  logic [31:0] store_data_in;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [1:0]  mem_len_out;
  logic        mem_done_in;
  logic [31:0] mem_rdata_in;
  logic        stall_req_out;
  logic [4:0]  rsd_addr_out;
  logic [31:0] rsd_data_out;
  logic        write_rsd_or_not_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_stage dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .cmdtype_in           (cmdtype_in),
    .rsd_addr_in          (rsd_addr_in),
    .rsd_data_in          (rsd_data_in),
    .write_rsd_or_not_in  (write_rsd_or_not_in),
    .mem_addr_in          (mem_addr_in),
    .store_data_in        (store_data_in),
    .mem_req_out          (mem_req_out),
    .mem_we_out           (mem_we_out),
    .mem_addr_out         (mem_addr_out),
    .mem_wdata_out        (mem_wdata_out),
    .mem_len_out          (mem_len_out),
    .mem_done_in          (mem_done_in),
    .mem_rdata_in         (mem_rdata_in),
    .stall_req_out        (stall_req_out),
    .rsd_addr_out         (rsd_addr_out),
    .rsd_data_out         (rsd_data_out),
    .write_rsd_or_not_out (write_rsd_or_not_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One complete memory op from IDLE, done pulse on the last of nbusy BUSY cycles.
  task automatic mem_op(input string tag, input logic [5:0] cmd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rsd,
                        input logic [31:0] rdata, input int nbusy,
                        input logic [1:0] exp_len, input logic exp_we,
                        input logic chk_data, input logic [31:0] exp_data,
                        input logic exp_wr);
    int stall_cnt;
    int req_cnt;
    stall_cnt = 0;
    req_cnt   = 0;
    cmdtype_in          = cmd;
    mem_addr_in         = addr;
    store_data_in       = wdata;
    rsd_addr_in         = rsd;
    rsd_data_in         = 32'h5A5A_5A5A;
    write_rsd_or_not_in = 1'b1;
    mem_done_in         = 1'b0;
    mem_rdata_in        = 32'h0;
    #1;
    check({tag, "_idle_stall"}, 32'(stall_req_out), 32'd1);
    check({tag, "_idle_wr"}, 32'(write_rsd_or_not_out), 32'd0);
    if (stall_req_out) stall_cnt++;
    for (int i = 0; i < nbusy; i++) begin
      tick();
      if (i == nbusy - 1) begin
        mem_done_in  = 1'b1;
        mem_rdata_in = rdata;
      end
      #1;
      if (stall_req_out) stall_cnt++;
      if (mem_req_out) req_cnt++;
      check({tag, "_addr"}, mem_addr_out, addr);
      check({tag, "_wdata"}, mem_wdata_out, wdata);
      check({tag, "_len"}, 32'(mem_len_out), 32'(exp_len));
      check({tag, "_we"}, 32'(mem_we_out), 32'(exp_we));
      check({tag, "_busy_wr"}, 32'(write_rsd_or_not_out), 32'd0);
    end
    tick();
    mem_done_in  = 1'b0;
    mem_rdata_in = 32'hFFFF_FFFF;
    #1;
    if (stall_req_out) stall_cnt++;
    if (mem_req_out) req_cnt++;
    if (chk_data) check({tag, "_data"}, rsd_data_out, exp_data);
    check({tag, "_done_wr"}, 32'(write_rsd_or_not_out), 32'(exp_wr));
    check({tag, "_done_rsd"}, 32'(rsd_addr_out), 32'(rsd));
    tick();
    cmdtype_in          = CMD_NOP;
    write_rsd_or_not_in = 1'b0;
    #1;
    check({tag, "_end_req"}, 32'(mem_req_out), 32'd0);
    check({tag, "_end_stall"}, 32'(stall_req_out), 32'd0);
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(nbusy + 1));
    check({tag, "_req_cycles"}, 32'(req_cnt), 32'(nbusy));
  endtask

  initial begin
    rst_in              = 1'b1;
    rdy_in              = 1'b1;
    cmdtype_in          = CMD_NOP;
    rsd_addr_in         = 5'd0;
    rsd_data_in         = 32'h0;
    write_rsd_or_not_in = 1'b1;
    mem_addr_in         = 32'hAAAA_0000;
    store_data_in       = 32'hBBBB_0000;
    mem_done_in         = 1'b1;
    mem_rdata_in        = 32'h0;

    // Reset state, and gated outputs while reset is held.
    tick();
    tick();
    check("rst_req", 32'(mem_req_out), 32'd0);
    check("rst_we", 32'(mem_we_out), 32'd0);
    check("rst_addr", mem_addr_out, 32'h0);
    check("rst_wdata", mem_wdata_out, 32'h0);
    check("rst_len", 32'(mem_len_out), 32'd0);
    check("rst_stall", 32'(stall_req_out), 32'd0);
    check("rst_wr", 32'(write_rsd_or_not_out), 32'd0);
    cmdtype_in = CMD_LW;
    #1;
    check("rst_stall_memcmd", 32'(stall_req_out), 32'd0);
    cmdtype_in  = CMD_NOP;
    mem_done_in = 1'b0;
    rst_in      = 1'b0;

    // Non-memory op passes straight through.
    tick();
    cmdtype_in          = CMD_ADD;
    rsd_addr_in         = 5'd3;
    rsd_data_in         = 32'h7;
    write_rsd_or_not_in = 1'b1;
    #1;
    check("add_rsd", 32'(rsd_addr_out), 32'd3);
    check("add_data", rsd_data_out, 32'h7);
    check("add_wr", 32'(write_rsd_or_not_out), 32'd1);
    check("add_stall", 32'(stall_req_out), 32'd0);
    tick();
    check("add_req", 32'(mem_req_out), 32'd0);
    check("add_stay_idle", 32'(stall_req_out), 32'd0);

    // Done pulse in IDLE is ignored.
    cmdtype_in  = CMD_NOP;
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    #1;
    check("idle_done_req", 32'(mem_req_out), 32'd0);
    check("idle_done_stall", 32'(stall_req_out), 32'd0);

    mem_op("lw",  CMD_LW,  32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF, 3, 2'b11, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    mem_op("lb",  CMD_LB,  32'h104, 32'h0, 5'd6, 32'h0000_0080, 1, 2'b00, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b1);
    mem_op("lbu", CMD_LBU, 32'h105, 32'h0, 5'd7, 32'h0000_0080, 2, 2'b00, 1'b0, 1'b1, 32'h0000_0080, 1'b1);
    mem_op("lh",  CMD_LH,  32'h106, 32'h0, 5'd8, 32'h0000_F00F, 1, 2'b01, 1'b0, 1'b1, 32'hFFFF_F00F, 1'b1);
    mem_op("lhu", CMD_LHU, 32'h108, 32'h0, 5'd9, 32'h0000_F00F, 1, 2'b01, 1'b0, 1'b1, 32'h0000_F00F, 1'b1);
    mem_op("sh",  CMD_SH,  32'h20, 32'h1234_5678, 5'd4, 32'h0, 2, 2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    mem_op("sb",  CMD_SB,  32'h21, 32'h0000_00A5, 5'd4, 32'h0, 1, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
    mem_op("sw",  CMD_SW,  32'h24, 32'hCAFE_F00D, 5'd4, 32'h0, 1, 2'b11, 1'b1, 1'b0, 32'h0, 1'b0);

    // Reset while BUSY abandons the access.
    cmdtype_in          = CMD_LW;
    mem_addr_in         = 32'h300;
    rsd_addr_in         = 5'd10;
    write_rsd_or_not_in = 1'b1;
    tick();
    check("rb_busy_req", 32'(mem_req_out), 32'd1);
    rst_in     = 1'b1;
    cmdtype_in = CMD_NOP;
    tick();
    check("rb_req", 32'(mem_req_out), 32'd0);
    check("rb_addr", mem_addr_out, 32'h0);
    check("rb_stall", 32'(stall_req_out), 32'd0);
    check("rb_wr", 32'(write_rsd_or_not_out), 32'd0);
    rst_in              = 1'b0;
    write_rsd_or_not_in = 1'b0;
    mem_done_in         = 1'b1;
    mem_rdata_in        = 32'h1111_1111;
    tick();
    mem_done_in = 1'b0;
    #1;
    check("rb_late_done_req", 32'(mem_req_out), 32'd0);
    check("rb_late_done_stall", 32'(stall_req_out), 32'd0);
    check("rb_late_done_wr", 32'(write_rsd_or_not_out), 32'd0);

    // rdy_in low freezes BUSY; a done pulse during the freeze is lost; LW to x0.
    cmdtype_in    = CMD_LW;
    mem_addr_in   = 32'h44;
    rsd_addr_in   = 5'd0;
    store_data_in = 32'h0;
    tick();
    check("rdy_req", 32'(mem_req_out), 32'd1);
    rdy_in      = 1'b0;
    mem_addr_in = 32'h999;
    tick();
    check("rdy_hold_addr1", mem_addr_out, 32'h44);
    check("rdy_hold_req1", 32'(mem_req_out), 32'd1);
    mem_done_in  = 1'b1;
    mem_rdata_in = 32'h2222_2222;
    tick();
    check("rdy_hold_addr2", mem_addr_out, 32'h44);
    check("rdy_hold_len2", 32'(mem_len_out), 32'd3);
    check("rdy_hold_stall2", 32'(stall_req_out), 32'd1);
    rdy_in      = 1'b1;
    mem_done_in = 1'b0;
    tick();
    check("rdy_lost_done_req", 32'(mem_req_out), 32'd1);
    mem_done_in  = 1'b1;
    mem_rdata_in = 32'h3333_4444;
    tick();
    mem_done_in = 1'b0;
    #1;
    check("rdy_done_req", 32'(mem_req_out), 32'd0);
    check("rdy_done_data", rsd_data_out, 32'h3333_4444);
    check("rdy_done_wr_x0", 32'(write_rsd_or_not_out), 32'd0);
    check("rdy_done_stall", 32'(stall_req_out), 32'd0);
    tick();
    cmdtype_in = CMD_NOP;
    #1;
    check("rdy_back_idle", 32'(mem_req_out | stall_req_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and one reset: clock clk_in, reset rst_in, reset synchronous and active-high.
REQ-002 clk_in  input  1  rising-edge clock.
REQ-003 rst_in  input  1  synchronous active-high reset.
REQ-004 rdy_in  input  1  global ready; low freezes all state.
REQ-005 cmdtype_in  input  6  instruction type from the EX/MEM register; codes LB, LH, LW, LBU, LHU, SB, SH, SW from the shared define file; any other code is non-memory.
REQ-006 rsd_addr_in  input  5  destination register.
REQ-007 rsd_data_in  input  32  ALU result (non-memory ops).
REQ-008 write_rsd_or_not_in  input  1  write-back enable (non-memory ops).
REQ-009 mem_addr_in  input  32  load/store byte address.
REQ-010 store_data_in  input  32  store data, LSBs significant.
REQ-011 mem_req_out  output  1  request to memory controller.
REQ-012 mem_we_out  output  1  1 = store, 0 = load.
REQ-013 mem_addr_out  output  32  request address.
REQ-014 mem_wdata_out  output  32  store data.
REQ-015 mem_len_out  output  2  access size: 00 = byte, 01 = half, 11 = word.
REQ-016 mem_done_in  input  1  one-cycle completion pulse from the controller.
REQ-017 mem_rdata_in  input  32  load data, LSB-aligned, valid with mem_done_in.
REQ-018 stall_req_out  output  1  stall request to the stall controller.
REQ-019 rsd_addr_out / rsd_data_out / write_rsd_or_not_out  output  5/32/1  to the MEM/WB register.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-021 IDLE, non-memory cmd: outputs combinationally equal the inputs (rsd_addr, rsd_data, write_rsd); stall_req_out=0; the FSM stays in IDLE.
REQ-022 IDLE, memory cmd: stall_req_out=1 combinationally; at the next edge the FSM enters BUSY, registers mem_req_out=1, and registers addr, we, wdata and len from the inputs.
REQ-023 BUSY: stall_req_out=1; the request fields are held constant; write_rsd_or_not_out=0; the FSM stays in BUSY until mem_done_in=1.
REQ-024 BUSY with mem_done_in=1: at that edge mem_req_out drops to 0, the extended load data is latched, and the FSM enters DONE.
REQ-025 DONE: stall_req_out=0; rsd_addr_out=rsd_addr_in; rsd_data_out=latched data; write_rsd_or_not_out=1 only for a load with rsd≠0; at the next edge the FSM returns to IDLE.
REQ-026 Load extension: LB sign-extends rdata[7:0]; LBU zero-extends rdata[7:0]; LH sign-extends rdata[15:0]; LHU zero-extends rdata[15:0]; LW takes the full 32 bits.
REQ-027 Stores: SB/SH/SW set len 00/01/11 and mem_we_out=1; write_rsd_or_not_out=0 in every state.
REQ-028 mem_done_in in IDLE or DONE SHALL be ignored.
REQ-029 Minimum memory-op latency: 1 IDLE cycle + ≥1 BUSY cycle + 1 DONE cycle; stall_req_out is high from the IDLE detect cycle through the last BUSY cycle.
REQ-030 rdy_in=0: no state or register update; outputs hold; a done pulse during rdy_in=0 is lost (the controller shares rdy_in).
REQ-031 Only one outstanding request; no new request is issued before returning to IDLE.

Reset
REQ-032 rst_in=1 at an edge SHALL force: state IDLE, mem_req_out=0, mem_we_out=0, mem_addr_out=0, mem_wdata_out=0, mem_len_out=00, latched data=0.
REQ-033 Reset SHALL take priority over rdy_in and mem_done_in.
REQ-034 Reset in BUSY or DONE abandons the access; the request drops at that edge and no write-back occurs.
REQ-035 While rst_in=1, stall_req_out=0 and write_rsd_or_not_out=0.

Verification
REQ-036 LW, addr 0x100, rsd 5, done after 3 BUSY cycles with rdata 0xDEADBEEF -> mem_req high 3 cycles with len 11 and we 0; DONE gives rsd_data_out 0xDEADBEEF and write 1; stall high for 4 cycles.
REQ-037 LB with rdata 0x00000080 -> rsd_data_out 0xFFFFFF80; LBU -> 0x00000080; LH with 0x0000F00F -> 0xFFFFF00F.
REQ-038 SH, addr 0x20, store data 0x12345678 -> mem_we_out 1, len 01, wdata 0x12345678, write_rsd_or_not_out 0 throughout.
REQ-039 ADD-type cmd, rsd 3, data 0x7 -> same-cycle pass-through; stall 0; mem_req 0.
REQ-040 rst_in pulsed in BUSY -> next cycle state IDLE, mem_req 0; a later done pulse is ignored.
REQ-041 rdy_in low 2 cycles in BUSY, then done -> request held unchanged; completes normally after rdy_in returns; LW to rsd 0 -> write 0.
